// File: rtl/match_controller.sv
// match_controller: two-player hit resolver and round sequencer (IDLE/INTRO/FIGHT/KO/MATCH_OVER).
// Optional round clock: define ROUND_TIMER_EN to make rounds end on timeout as well as on KO.

module match_controller #(
  parameter int MAX_HEALTH     = 100,
  parameter int DAMAGE         = 10,
  parameter int HITSTUN_FRAMES = 20,
  parameter int INTRO_FRAMES   = 120,
  parameter int KO_FRAMES      = 180,
  parameter int FPS            = 60,
  parameter int ROUND_SECS     = 60,
  parameter int ROUNDS_TO_WIN  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCEN,
  input  logic       start,
  input  logic [9:0] p1_pos_x,
  input  logic [9:0] p1_pos_y,
  input  logic       p1_facing,
  input  logic       p1_attack_damage,
  input  logic [9:0] p2_pos_x,
  input  logic [9:0] p2_pos_y,
  input  logic       p2_facing,
  input  logic       p2_attack_damage,
  output logic [7:0] p1_health,
  output logic [7:0] p2_health,
  output logic       p1_hitstun_active,
  output logic       p2_hitstun_active,
  output logic       p1_ctrl_enable,
  output logic       p2_ctrl_enable,
  output logic       p1_hit_pulse,
  output logic       p2_hit_pulse,
  output logic [2:0] match_state,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [1:0] winner,
  output logic [6:0] round_time
);

  localparam int STUN_W = $clog2(HITSTUN_FRAMES + 1);
  localparam int PH_W   = $clog2(((INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES) + 1);
  localparam int SEC_W  = $clog2(FPS + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INTRO = 3'd1,
    ST_FIGHT = 3'd2,
    ST_KO    = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Attacker hitbox (40x80) against defender hurtbox (40x45); 11-bit signed keeps
  // pos_x-5 from wrapping at the left screen edge. Touching edges do not overlap.
  function automatic logic hitbox_overlaps(
    input logic [9:0] atk_x,
    input logic [9:0] atk_y,
    input logic       atk_facing,
    input logic [9:0] def_x,
    input logic [9:0] def_y
  );
    logic signed [10:0] hx;
    logic signed [10:0] hy;
    logic signed [10:0] ux;
    logic signed [10:0] uy;
    hx = atk_facing ? ($signed({1'b0, atk_x}) + 11'sd85) : ($signed({1'b0, atk_x}) - 11'sd5);
    hy = $signed({1'b0, atk_y}) - 11'sd5;
    ux = $signed({1'b0, def_x}) + 11'sd40;
    uy = $signed({1'b0, def_y}) + 11'sd53;
    return (hx < (ux + 11'sd40)) && (ux < (hx + 11'sd40)) &&
           (hy < (uy + 11'sd45)) && (uy < (hy + 11'sd80));
  endfunction

  state_t             state_r, state_s;
  logic [7:0]         p1_health_r, p1_health_s, p2_health_r, p2_health_s;
  logic [STUN_W-1:0]  p1_stun_r, p1_stun_s, p2_stun_r, p2_stun_s;
  logic               p1_latch_r, p1_latch_s, p2_latch_r, p2_latch_s;
  logic [1:0]         p1_rounds_r, p1_rounds_s, p2_rounds_r, p2_rounds_s;
  logic [1:0]         winner_r, winner_s;
  logic [6:0]         round_time_r, round_time_s;
  logic [PH_W-1:0]    phase_r, phase_s;
  logic [SEC_W-1:0]   sec_r, sec_s;
  logic               p1_hitstun_r, p2_hitstun_r;
  logic               p1_ctrl_r, p2_ctrl_r;
  logic               p1_pulse_r, p2_pulse_r;
  logic               p1_reach_s, p2_reach_s;
  logic               hit_on_p1_s, hit_on_p2_s;
  logic               enter_intro_s;
  logic               timeout_s;

  assign p1_reach_s  = hitbox_overlaps(p1_pos_x, p1_pos_y, p1_facing, p2_pos_x, p2_pos_y);
  assign p2_reach_s  = hitbox_overlaps(p2_pos_x, p2_pos_y, p2_facing, p1_pos_x, p1_pos_y);
  assign hit_on_p2_s = SCEN && (state_r == ST_FIGHT) && p1_attack_damage && p1_reach_s &&
                       (p1_stun_r == STUN_W'(0)) && !p1_latch_r;
  assign hit_on_p1_s = SCEN && (state_r == ST_FIGHT) && p2_attack_damage && p2_reach_s &&
                       (p2_stun_r == STUN_W'(0)) && !p2_latch_r;

  // Frame update: hits first, then round resolution and sequencing on the post-hit health.
  always_comb begin
    state_s       = state_r;
    p1_health_s   = p1_health_r;
    p2_health_s   = p2_health_r;
    p1_stun_s     = p1_stun_r;
    p2_stun_s     = p2_stun_r;
    p1_latch_s    = p1_latch_r;
    p2_latch_s    = p2_latch_r;
    p1_rounds_s   = p1_rounds_r;
    p2_rounds_s   = p2_rounds_r;
    winner_s      = winner_r;
    round_time_s  = round_time_r;
    phase_s       = phase_r;
    sec_s         = sec_r;
    enter_intro_s = 1'b0;
    timeout_s     = 1'b0;
    if (SCEN) begin
      p1_stun_s  = (p1_stun_r != STUN_W'(0)) ? (p1_stun_r - STUN_W'(1)) : p1_stun_r;
      p2_stun_s  = (p2_stun_r != STUN_W'(0)) ? (p2_stun_r - STUN_W'(1)) : p2_stun_r;
      p1_latch_s = p1_attack_damage ? p1_latch_r : 1'b0;
      p2_latch_s = p2_attack_damage ? p2_latch_r : 1'b0;
      if (hit_on_p2_s) begin
        p2_health_s = (p2_health_r > 8'(DAMAGE)) ? (p2_health_r - 8'(DAMAGE)) : 8'd0;
        p2_stun_s   = STUN_W'(HITSTUN_FRAMES);
        p1_latch_s  = 1'b1;
      end else begin
        p2_health_s = p2_health_r;
      end
      if (hit_on_p1_s) begin
        p1_health_s = (p1_health_r > 8'(DAMAGE)) ? (p1_health_r - 8'(DAMAGE)) : 8'd0;
        p1_stun_s   = STUN_W'(HITSTUN_FRAMES);
        p2_latch_s  = 1'b1;
      end else begin
        p1_health_s = p1_health_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s       = ST_INTRO;
            p1_rounds_s   = 2'd0;
            p2_rounds_s   = 2'd0;
            winner_s      = 2'd0;
            enter_intro_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_INTRO: begin
          if (phase_r == PH_W'(INTRO_FRAMES - 1)) begin
            state_s = ST_FIGHT;
            phase_s = PH_W'(0);
          end else begin
            phase_s = phase_r + PH_W'(1);
          end
        end
        ST_FIGHT: begin
          phase_s = PH_W'(0);
`ifdef ROUND_TIMER_EN
          if (sec_r == SEC_W'(FPS - 1)) begin
            sec_s        = SEC_W'(0);
            round_time_s = round_time_r - 7'd1;
          end else begin
            sec_s = sec_r + SEC_W'(1);
          end
          timeout_s = (round_time_s == 7'd0);
`endif
          // A KO on the same frame as the timeout decides the round.
          if ((p1_health_s == 8'd0) && (p2_health_s == 8'd0)) begin
            winner_s = 2'd3;
            state_s  = ST_KO;
          end else if (p1_health_s == 8'd0) begin
            p2_rounds_s = p2_rounds_r + 2'd1;
            winner_s    = 2'd2;
            state_s     = ST_KO;
          end else if (p2_health_s == 8'd0) begin
            p1_rounds_s = p1_rounds_r + 2'd1;
            winner_s    = 2'd1;
            state_s     = ST_KO;
          end else if (timeout_s) begin
            state_s = ST_KO;
            if (p1_health_s > p2_health_s) begin
              p1_rounds_s = p1_rounds_r + 2'd1;
              winner_s    = 2'd1;
            end else if (p2_health_s > p1_health_s) begin
              p2_rounds_s = p2_rounds_r + 2'd1;
              winner_s    = 2'd2;
            end else begin
              winner_s = 2'd3;
            end
          end else begin
            state_s = ST_FIGHT;
          end
        end
        ST_KO: begin
          if (phase_r == PH_W'(KO_FRAMES - 1)) begin
            phase_s = PH_W'(0);
            if ((p1_rounds_r == 2'(ROUNDS_TO_WIN)) || (p2_rounds_r == 2'(ROUNDS_TO_WIN))) begin
              state_s = ST_OVER;
            end else begin
              state_s       = ST_INTRO;
              enter_intro_s = 1'b1;
            end
          end else begin
            phase_s = phase_r + PH_W'(1);
          end
        end
        ST_OVER: begin
          if (start) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_OVER;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase

      p1_health_s  = enter_intro_s ? 8'(MAX_HEALTH) : p1_health_s;
      p2_health_s  = enter_intro_s ? 8'(MAX_HEALTH) : p2_health_s;
      p1_stun_s    = enter_intro_s ? STUN_W'(0) : p1_stun_s;
      p2_stun_s    = enter_intro_s ? STUN_W'(0) : p2_stun_s;
      p1_latch_s   = enter_intro_s ? 1'b0 : p1_latch_s;
      p2_latch_s   = enter_intro_s ? 1'b0 : p2_latch_s;
      round_time_s = enter_intro_s ? 7'(ROUND_SECS) : round_time_s;
      sec_s        = enter_intro_s ? SEC_W'(0) : sec_s;
      phase_s      = enter_intro_s ? PH_W'(0) : phase_s;
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers; flags are derived from next-state values so they stay registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      p1_health_r  <= 8'(MAX_HEALTH);
      p2_health_r  <= 8'(MAX_HEALTH);
      p1_stun_r    <= STUN_W'(0);
      p2_stun_r    <= STUN_W'(0);
      p1_latch_r   <= 1'b0;
      p2_latch_r   <= 1'b0;
      p1_rounds_r  <= 2'd0;
      p2_rounds_r  <= 2'd0;
      winner_r     <= 2'd0;
      round_time_r <= 7'(ROUND_SECS);
      phase_r      <= PH_W'(0);
      sec_r        <= SEC_W'(0);
      p1_hitstun_r <= 1'b0;
      p2_hitstun_r <= 1'b0;
      p1_ctrl_r    <= 1'b0;
      p2_ctrl_r    <= 1'b0;
      p1_pulse_r   <= 1'b0;
      p2_pulse_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      p1_health_r  <= p1_health_s;
      p2_health_r  <= p2_health_s;
      p1_stun_r    <= p1_stun_s;
      p2_stun_r    <= p2_stun_s;
      p1_latch_r   <= p1_latch_s;
      p2_latch_r   <= p2_latch_s;
      p1_rounds_r  <= p1_rounds_s;
      p2_rounds_r  <= p2_rounds_s;
      winner_r     <= winner_s;
      round_time_r <= round_time_s;
      phase_r      <= phase_s;
      sec_r        <= sec_s;
      p1_hitstun_r <= (p1_stun_s != STUN_W'(0));
      p2_hitstun_r <= (p2_stun_s != STUN_W'(0));
      p1_ctrl_r    <= (state_s == ST_FIGHT) && (p1_stun_s == STUN_W'(0));
      p2_ctrl_r    <= (state_s == ST_FIGHT) && (p2_stun_s == STUN_W'(0));
      p1_pulse_r   <= hit_on_p1_s;
      p2_pulse_r   <= hit_on_p2_s;
    end
  end

  assign match_state       = state_r;
  assign p1_health         = p1_health_r;
  assign p2_health         = p2_health_r;
  assign p1_hitstun_active = p1_hitstun_r;
  assign p2_hitstun_active = p2_hitstun_r;
  assign p1_ctrl_enable    = p1_ctrl_r;
  assign p2_ctrl_enable    = p2_ctrl_r;
  assign p1_hit_pulse      = p1_pulse_r;
  assign p2_hit_pulse      = p2_pulse_r;
  assign p1_rounds         = p1_rounds_r;
  assign p2_rounds         = p2_rounds_r;
  assign winner            = winner_r;
  assign round_time        = round_time_r;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed round scenarios plus randomized play,
// every cycle compared against a frame-level behavioural model (stun tracked as an end frame).

module tb_match_controller;

  localparam int MAX_HEALTH     = 100;
  localparam int DAMAGE         = 10;
  localparam int HITSTUN_FRAMES = 20;
  localparam int INTRO_FRAMES   = 120;
  localparam int KO_FRAMES      = 180;
  localparam int FPS            = 60;
  localparam int ROUND_SECS     = 60;
  localparam int ROUNDS_TO_WIN  = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       SCEN;
  logic       start;
  logic [9:0] p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y;
  logic       p1_facing, p2_facing, p1_attack_damage, p2_attack_damage;
  logic [7:0] p1_health, p2_health;
  logic       p1_hitstun_active, p2_hitstun_active;
  logic       p1_ctrl_enable, p2_ctrl_enable;
  logic       p1_hit_pulse, p2_hit_pulse;
  logic [2:0] match_state;
  logic [1:0] p1_rounds, p2_rounds, winner;
  logic [6:0] round_time;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int n_p2_pulses = 0;

  // Model state
  int m_state, m_h1, m_h2, m_r1, m_r2, m_win;
  int m_frame, m_end1, m_end2, m_lat1, m_lat2;
  int m_left, m_fight_frames, m_pulse1, m_pulse2;

  always #5 clk = ~clk;

  match_controller dut (
    .clk(clk), .reset_n(reset_n), .SCEN(SCEN), .start(start),
    .p1_pos_x(p1_pos_x), .p1_pos_y(p1_pos_y), .p1_facing(p1_facing),
    .p1_attack_damage(p1_attack_damage),
    .p2_pos_x(p2_pos_x), .p2_pos_y(p2_pos_y), .p2_facing(p2_facing),
    .p2_attack_damage(p2_attack_damage),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_hitstun_active(p1_hitstun_active), .p2_hitstun_active(p2_hitstun_active),
    .p1_ctrl_enable(p1_ctrl_enable), .p2_ctrl_enable(p2_ctrl_enable),
    .p1_hit_pulse(p1_hit_pulse), .p2_hit_pulse(p2_hit_pulse),
    .match_state(match_state), .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
    .winner(winner), .round_time(round_time)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    checks_cnt++;
    if (obs != exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reaches(input int ax, input int ay, input bit face, input int dx, input int dy);
    int hx, hy, ux, uy;
    hx = face ? ax + 85 : ax - 5;
    hy = ay - 5;
    ux = dx + 40;
    uy = dy + 53;
    return (hx < ux + 40) && (ux < hx + 40) && (hy < uy + 45) && (uy < hy + 80);
  endfunction

  function automatic int m_round_time();
`ifdef ROUND_TIMER_EN
    return ROUND_SECS - m_fight_frames / FPS;
`else
    return ROUND_SECS;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_h1 = MAX_HEALTH; m_h2 = MAX_HEALTH;
    m_r1 = 0; m_r2 = 0; m_win = 0;
    m_frame = 0; m_end1 = 0; m_end2 = 0; m_lat1 = 0; m_lat2 = 0;
    m_left = 0; m_fight_frames = 0; m_pulse1 = 0; m_pulse2 = 0;
  endtask

  task automatic enter_intro();
    m_state = 1; m_left = INTRO_FRAMES;
    m_h1 = MAX_HEALTH; m_h2 = MAX_HEALTH;
    m_end1 = m_frame; m_end2 = m_frame;
    m_lat1 = 0; m_lat2 = 0; m_fight_frames = 0;
  endtask

  task automatic model_frame();
    bit st1, st2, hit1, hit2, ko;
    st1 = (m_end1 > m_frame);
    st2 = (m_end2 > m_frame);
    m_frame++;
    hit2 = (m_state == 2) && p1_attack_damage && !st1 && (m_lat1 == 0) &&
           reaches(p1_pos_x, p1_pos_y, p1_facing, p2_pos_x, p2_pos_y);
    hit1 = (m_state == 2) && p2_attack_damage && !st2 && (m_lat2 == 0) &&
           reaches(p2_pos_x, p2_pos_y, p2_facing, p1_pos_x, p1_pos_y);
    m_pulse1 = hit1;
    m_pulse2 = hit2;
    if (!p1_attack_damage) m_lat1 = 0;
    if (!p2_attack_damage) m_lat2 = 0;
    if (hit2) begin
      m_h2 = (m_h2 > DAMAGE) ? m_h2 - DAMAGE : 0;
      m_end2 = m_frame + HITSTUN_FRAMES;
      m_lat1 = 1;
    end
    if (hit1) begin
      m_h1 = (m_h1 > DAMAGE) ? m_h1 - DAMAGE : 0;
      m_end1 = m_frame + HITSTUN_FRAMES;
      m_lat2 = 1;
    end
    case (m_state)
      0: if (start) begin m_r1 = 0; m_r2 = 0; m_win = 0; enter_intro(); end
      1: begin m_left--; if (m_left == 0) m_state = 2; end
      2: begin
        m_fight_frames++;
        ko = 1;
        if (m_h1 == 0 && m_h2 == 0) m_win = 3;
        else if (m_h1 == 0) begin m_r2++; m_win = 2; end
        else if (m_h2 == 0) begin m_r1++; m_win = 1; end
`ifdef ROUND_TIMER_EN
        else if (m_round_time() == 0) begin
          if (m_h1 > m_h2) begin m_r1++; m_win = 1; end
          else if (m_h2 > m_h1) begin m_r2++; m_win = 2; end
          else m_win = 3;
        end
`endif
        else ko = 0;
        if (ko) begin m_state = 3; m_left = KO_FRAMES; end
      end
      3: begin
        m_left--;
        if (m_left == 0) begin
          if (m_r1 == ROUNDS_TO_WIN || m_r2 == ROUNDS_TO_WIN) m_state = 4;
          else enter_intro();
        end
      end
      default: if (start) m_state = 0;
    endcase
  endtask

  task automatic compare_all();
    check_val("state", match_state, m_state);
    check_val("p1_health", p1_health, m_h1);
    check_val("p2_health", p2_health, m_h2);
    check_val("p1_hitstun", p1_hitstun_active, m_end1 > m_frame);
    check_val("p2_hitstun", p2_hitstun_active, m_end2 > m_frame);
    check_val("p1_ctrl", p1_ctrl_enable, (m_state == 2) && !(m_end1 > m_frame));
    check_val("p2_ctrl", p2_ctrl_enable, (m_state == 2) && !(m_end2 > m_frame));
    check_val("p1_pulse", p1_hit_pulse, m_pulse1);
    check_val("p2_pulse", p2_hit_pulse, m_pulse2);
    check_val("p1_rounds", p1_rounds, m_r1);
    check_val("p2_rounds", p2_rounds, m_r2);
    check_val("winner", winner, m_win);
    check_val("round_time", round_time, m_round_time());
  endtask

  // One clock: inputs set at the negedge, model advanced at the posedge, outputs checked next negedge.
  task automatic step(input bit scen);
    SCEN = scen;
    @(posedge clk);
    if (scen) model_frame();
    else begin m_pulse1 = 0; m_pulse2 = 0; end
    @(negedge clk);
    compare_all();
    if (p2_hit_pulse) n_p2_pulses++;
  endtask

  task automatic frame();
    step(1'b1);
    if ($urandom_range(0, 1) == 1) step(1'b0);
  endtask

  task automatic rand_inputs();
    p1_pos_x = 10'($urandom_range(60, 200));
    p2_pos_x = 10'($urandom_range(100, 240));
    p1_pos_y = 10'($urandom_range(180, 230));
    p2_pos_y = 10'($urandom_range(180, 230));
    p1_facing = ($urandom_range(0, 9) < 8);
    p2_facing = ($urandom_range(0, 9) < 2);
    p1_attack_damage = ($urandom_range(0, 99) < 45);
    p2_attack_damage = ($urandom_range(0, 99) < 45);
    start = ($urandom_range(0, 99) < 8);
  endtask

  task automatic rand_frame();
    int gap;
    rand_inputs();
    step(1'b1);
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      rand_inputs();
      step(1'b0);
    end
  endtask

  task automatic mid_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;
  endtask

  task automatic p1_ko_round();
    for (int i = 0; i < 40; i++) begin
      p1_attack_damage = 1'b1;
      frame();
      p1_attack_damage = 1'b0;
      if (m_state != 2) break;
      frame();
    end
  endtask

  initial begin
    reset_n = 1'b0; SCEN = 1'b0; start = 1'b0;
    p1_pos_x = 10'd100; p1_pos_y = 10'd200; p1_facing = 1'b1; p1_attack_damage = 1'b0;
    p2_pos_x = 10'd150; p2_pos_y = 10'd200; p2_facing = 1'b0; p2_attack_damage = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    reset_n = 1'b1;
    repeat (3) frame();

    start = 1'b1; frame(); start = 1'b0;
    check_val("start_to_intro", match_state, 1);
    repeat (INTRO_FRAMES - 1) frame();
    check_val("intro_hold", match_state, 1);
    frame();
    check_val("intro_to_fight", match_state, 2);
    check_val("fight_p1_health", p1_health, 100);
    check_val("fight_p1_ctrl", p1_ctrl_enable, 1);

    // Held attack lands exactly once; P2 stunned for 20 frames.
    n_p2_pulses = 0;
    p1_attack_damage = 1'b1; repeat (7) frame(); p1_attack_damage = 1'b0;
    check_val("one_hit_pulses", n_p2_pulses, 1);
    check_val("one_hit_health", p2_health, 90);
    repeat (13) frame();
    check_val("stun_last_frame", p2_hitstun_active, 1);
    check_val("stun_ctrl_off", p2_ctrl_enable, 0);
    frame();
    check_val("stun_expired", p2_hitstun_active, 0);
    check_val("stun_ctrl_on", p2_ctrl_enable, 1);

    // Trade: both attack on the same frame.
    p1_attack_damage = 1'b1; p2_attack_damage = 1'b1; frame();
    p1_attack_damage = 1'b0; p2_attack_damage = 1'b0;
    check_val("trade_p1", p1_health, 90);
    check_val("trade_p2", p2_health, 80);
    check_val("trade_stun1", p1_hitstun_active, 1);
    check_val("trade_stun2", p2_hitstun_active, 1);
    repeat (21) frame();

    p1_ko_round();
    check_val("ko_state", match_state, 3);
    check_val("ko_p2_health", p2_health, 0);
    check_val("ko_p1_rounds", p1_rounds, 1);
    check_val("ko_winner", winner, 1);
    repeat (KO_FRAMES - 1) frame();
    check_val("ko_hold", match_state, 3);
    frame();
    check_val("ko_to_intro", match_state, 1);
    check_val("intro_health", p2_health, 100);
    repeat (INTRO_FRAMES) frame();
    check_val("round2_fight", match_state, 2);
    p1_ko_round();
    check_val("round2_p1_rounds", p1_rounds, 2);
    repeat (KO_FRAMES) frame();
    check_val("match_over", match_state, 4);
    check_val("over_ctrl", p1_ctrl_enable, 0);

    start = 1'b1; frame();
    check_val("over_to_idle", match_state, 0);
    frame(); start = 1'b0;
    check_val("restart_intro", match_state, 1);
    check_val("restart_rounds", p1_rounds, 0);
    check_val("restart_winner", winner, 0);
    repeat (INTRO_FRAMES) frame();

    // Both down to 10, then a mutual hit draws the round.
    repeat (9) begin p1_attack_damage = 1'b1; frame(); p1_attack_damage = 1'b0; frame(); end
    repeat (21) frame();
    repeat (9) begin p2_attack_damage = 1'b1; frame(); p2_attack_damage = 1'b0; frame(); end
    repeat (21) frame();
    check_val("pre_draw_p1", p1_health, 10);
    check_val("pre_draw_p2", p2_health, 10);
    p1_attack_damage = 1'b1; p2_attack_damage = 1'b1; frame();
    p1_attack_damage = 1'b0; p2_attack_damage = 1'b0;
    check_val("draw_p1", p1_health, 0);
    check_val("draw_p2", p2_health, 0);
    check_val("draw_winner", winner, 3);
    check_val("draw_rounds", p1_rounds + p2_rounds, 0);
    check_val("draw_state", match_state, 3);
    repeat (KO_FRAMES) frame();
    check_val("draw_to_intro", match_state, 1);
    repeat (INTRO_FRAMES) frame();

`ifdef ROUND_TIMER_EN
    repeat (2) begin p2_attack_damage = 1'b1; frame(); p2_attack_damage = 1'b0; frame(); end
    repeat (21) frame();
    p1_attack_damage = 1'b1; frame(); p1_attack_damage = 1'b0;
    check_val("timer_p1", p1_health, 80);
    check_val("timer_p2", p2_health, 90);
    for (int i = 0; i < 4000; i++) begin
      frame();
      if (m_state != 2) break;
    end
    check_val("timeout_time", round_time, 0);
    check_val("timeout_state", match_state, 3);
    check_val("timeout_p2_rounds", p2_rounds, 1);
    check_val("timeout_winner", winner, 2);
    repeat (KO_FRAMES) frame();
`endif

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) mid_reset();
      rand_frame();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
